// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: forwarding mux select codes and register helpers.
// The EX operand muxes decode the same fwd_sel_t values produced by id_ex_stage.
package mips_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_SEL_REG   = 2'b00,
        FWD_SEL_MEMWB = 2'b01,
        FWD_SEL_EXMEM = 2'b10
    } fwd_sel_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // $0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic fwd_hit(input logic reg_write, input reg_idx_t dest, input reg_idx_t src);
        return reg_write && (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle between ID, the ID/EX register and EX: decoded inputs, later-stage destinations, EX-side outputs.
// The master side is the surrounding pipeline; the slave side is id_ex_stage.
interface id_ex_stage_if #(
    parameter int BUS_WIDTH = 32,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
);
    logic                 i_hold;
    logic                 i_flush;
    logic                 i_valid;
    logic [BUS_WIDTH-1:0] i_rs_data;
    logic [BUS_WIDTH-1:0] i_rt_data;
    logic [BUS_WIDTH-1:0] i_imm;
    logic [4:0]           i_rs;
    logic [4:0]           i_rt;
    logic                 i_uses_rt;
    logic [4:0]           i_dest;
    logic                 i_reg_write;
    logic                 i_mem_read;
    logic [CTRL_W-1:0]    i_ctrl;
    logic [4:0]           i_exmem_dest;
    logic                 i_exmem_reg_write;
    logic [4:0]           i_memwb_dest;
    logic                 i_memwb_reg_write;

    logic                 o_valid;
    logic [BUS_WIDTH-1:0] o_rs_data;
    logic [BUS_WIDTH-1:0] o_rt_data;
    logic [BUS_WIDTH-1:0] o_imm;
    logic [4:0]           o_rs;
    logic [4:0]           o_rt;
    logic [4:0]           o_dest;
    logic                 o_reg_write;
    logic                 o_mem_read;
    logic [CTRL_W-1:0]    o_ctrl;
    logic [1:0]           o_fwd_sel_a;
    logic [1:0]           o_fwd_sel_b;
    logic                 o_stall;
    logic [CNT_W-1:0]     o_stall_count;

    modport master (
        output i_hold, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_rs, i_rt, i_uses_rt,
               i_dest, i_reg_write, i_mem_read, i_ctrl, i_exmem_dest, i_exmem_reg_write,
               i_memwb_dest, i_memwb_reg_write,
        input  o_valid, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_dest, o_reg_write,
               o_mem_read, o_ctrl, o_fwd_sel_a, o_fwd_sel_b, o_stall, o_stall_count
    );

    modport slave (
        input  i_hold, i_flush, i_valid, i_rs_data, i_rt_data, i_imm, i_rs, i_rt, i_uses_rt,
               i_dest, i_reg_write, i_mem_read, i_ctrl, i_exmem_dest, i_exmem_reg_write,
               i_memwb_dest, i_memwb_reg_write,
        output o_valid, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_dest, o_reg_write,
               o_mem_read, o_ctrl, o_fwd_sel_a, o_fwd_sel_b, o_stall, o_stall_count
    );

endinterface

// File: rtl/id_ex_stage_fwd_select.sv
// Forwarding select for one EX operand: picks the youngest in-flight producer of the source register.
// Instantiated once per operand inside id_ex_stage.
module fwd_select
    import mips_pkg::*;
(
    input  logic     i_valid,
    input  reg_idx_t i_src,
    input  reg_idx_t i_exmem_dest,
    input  logic     i_exmem_reg_write,
    input  reg_idx_t i_memwb_dest,
    input  logic     i_memwb_reg_write,
    output fwd_sel_t o_sel
);

    // EX/MEM is checked first because it holds the newer value of a register written twice.
    always_comb begin
        o_sel = FWD_SEL_REG;
        if (i_valid) begin
            if (fwd_hit(i_exmem_reg_write, i_exmem_dest, i_src)) begin
                o_sel = FWD_SEL_EXMEM;
            end else if (fwd_hit(i_memwb_reg_write, i_memwb_dest, i_src)) begin
                o_sel = FWD_SEL_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding select generation, load-use stall detection
// and a saturating count of stall cycles.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int CTRL_W    = 8,
    parameter int CNT_W     = 16
) (
    input logic         i_clk,
    input logic         i_reset,
    id_ex_stage_if.slave bus
);

    logic                 r_valid;
    logic [BUS_WIDTH-1:0] r_rs_data;
    logic [BUS_WIDTH-1:0] r_rt_data;
    logic [BUS_WIDTH-1:0] r_imm;
    reg_idx_t             r_rs;
    reg_idx_t             r_rt;
    reg_idx_t             r_dest;
    logic                 r_reg_write;
    logic                 r_mem_read;
    logic [CTRL_W-1:0]    r_ctrl;
    logic [CNT_W-1:0]     r_stall_count;

    logic                 w_stall;
    fwd_sel_t             w_fwd_sel_a;
    fwd_sel_t             w_fwd_sel_b;

    // A load in EX cannot forward its data in time for a dependent instruction in ID.
    assign w_stall = r_valid & r_mem_read & (r_dest != REG_ZERO) &
                     ((r_dest == bus.i_rs) | (bus.i_uses_rt & (r_dest == bus.i_rt)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid       <= 1'b0;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_rs          <= REG_ZERO;
            r_rt          <= REG_ZERO;
            r_dest        <= REG_ZERO;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_ctrl        <= '0;
            r_stall_count <= '0;
        end else if (!bus.i_hold) begin
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            // Flush and stall share one bubble; data fields are zeroed so a bubble looks like reset.
            if (bus.i_flush || w_stall) begin
                r_valid     <= 1'b0;
                r_rs_data   <= '0;
                r_rt_data   <= '0;
                r_imm       <= '0;
                r_rs        <= REG_ZERO;
                r_rt        <= REG_ZERO;
                r_dest      <= REG_ZERO;
                r_reg_write <= 1'b0;
                r_mem_read  <= 1'b0;
                r_ctrl      <= '0;
            end else begin
                r_valid     <= bus.i_valid;
                r_rs_data   <= bus.i_rs_data;
                r_rt_data   <= bus.i_rt_data;
                r_imm       <= bus.i_imm;
                r_rs        <= bus.i_rs;
                r_rt        <= bus.i_rt;
                r_dest      <= bus.i_dest;
                r_reg_write <= bus.i_reg_write;
                r_mem_read  <= bus.i_mem_read;
                r_ctrl      <= bus.i_ctrl;
            end
        end
    end

    fwd_select u_fwd_a (
        .i_valid           (r_valid),
        .i_src             (r_rs),
        .i_exmem_dest      (bus.i_exmem_dest),
        .i_exmem_reg_write (bus.i_exmem_reg_write),
        .i_memwb_dest      (bus.i_memwb_dest),
        .i_memwb_reg_write (bus.i_memwb_reg_write),
        .o_sel             (w_fwd_sel_a)
    );

    fwd_select u_fwd_b (
        .i_valid           (r_valid),
        .i_src             (r_rt),
        .i_exmem_dest      (bus.i_exmem_dest),
        .i_exmem_reg_write (bus.i_exmem_reg_write),
        .i_memwb_dest      (bus.i_memwb_dest),
        .i_memwb_reg_write (bus.i_memwb_reg_write),
        .o_sel             (w_fwd_sel_b)
    );

    assign bus.o_valid       = r_valid;
    assign bus.o_rs_data     = r_rs_data;
    assign bus.o_rt_data     = r_rt_data;
    assign bus.o_imm         = r_imm;
    assign bus.o_rs          = r_rs;
    assign bus.o_rt          = r_rt;
    assign bus.o_dest        = r_dest;
    assign bus.o_reg_write   = r_reg_write;
    assign bus.o_mem_read    = r_mem_read;
    assign bus.o_ctrl        = r_ctrl;
    assign bus.o_fwd_sel_a   = w_fwd_sel_a;
    assign bus.o_fwd_sel_b   = w_fwd_sel_b;
    assign bus.o_stall       = w_stall;
    assign bus.o_stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/forwarding scenarios plus a random run
// compared against a cycle-level model of what EX should be holding.
module tb_id_ex_stage;

    localparam int BW    = 32;
    localparam int CW    = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.BUS_WIDTH(BW), .CTRL_W(CW), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.BUS_WIDTH(BW), .CTRL_W(CW), .CNT_W(CNT_W)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic          valid;
        logic [BW-1:0] rsd;
        logic [BW-1:0] rtd;
        logic [BW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    dest;
        logic          rw;
        logic          mr;
        logic [CW-1:0] ctrl;
    } instr_t;

    // Model: the instruction EX should hold and the number of stall cycles seen so far.
    instr_t mEx = '0;
    int     mCount = 0;

    function automatic instr_t idInstr();
        instr_t t;
        t.valid = bus.i_valid;    t.rsd = bus.i_rs_data;     t.rtd = bus.i_rt_data;
        t.imm   = bus.i_imm;      t.rs  = bus.i_rs;          t.rt  = bus.i_rt;
        t.dest  = bus.i_dest;     t.rw  = bus.i_reg_write;   t.mr  = bus.i_mem_read;
        t.ctrl  = bus.i_ctrl;
        return t;
    endfunction

    function automatic instr_t dutEx();
        instr_t t;
        t.valid = bus.o_valid;    t.rsd = bus.o_rs_data;     t.rtd = bus.o_rt_data;
        t.imm   = bus.o_imm;      t.rs  = bus.o_rs;          t.rt  = bus.o_rt;
        t.dest  = bus.o_dest;     t.rw  = bus.o_reg_write;   t.mr  = bus.o_mem_read;
        t.ctrl  = bus.o_ctrl;
        return t;
    endfunction

    function automatic logic modelStall();
        if (!(mEx.valid && mEx.mr) || mEx.dest == 5'd0) return 1'b0;
        return (mEx.dest == bus.i_rs) || (bus.i_uses_rt && mEx.dest == bus.i_rt);
    endfunction

    function automatic logic [1:0] modelFwd(input logic [4:0] src);
        if (!mEx.valid || src == 5'd0) return 2'd0;
        if (bus.i_exmem_reg_write && bus.i_exmem_dest == src) return 2'd2;
        if (bus.i_memwb_reg_write && bus.i_memwb_dest == src) return 2'd1;
        return 2'd0;
    endfunction

    // Advance one clock, applying the stage's update rules to the model.
    task automatic tick();
        instr_t nxt = mEx;
        int     nc  = mCount;
        if (reset) begin
            nxt = '0;
            nc  = 0;
        end else if (!bus.i_hold) begin
            if (modelStall()) begin
                nc  = (nc < MAXC) ? nc + 1 : nc;
                nxt = '0;
            end else if (bus.i_flush) begin
                nxt = '0;
            end else begin
                nxt = idInstr();
            end
        end
        @(posedge clk);
        #1;
        mEx    = nxt;
        mCount = nc;
    endtask

    task automatic setIdle();
        bus.i_hold = 0; bus.i_flush = 0; bus.i_valid = 0;
        bus.i_rs_data = '0; bus.i_rt_data = '0; bus.i_imm = '0;
        bus.i_rs = '0; bus.i_rt = '0; bus.i_uses_rt = 0; bus.i_dest = '0;
        bus.i_reg_write = 0; bus.i_mem_read = 0; bus.i_ctrl = '0;
        bus.i_exmem_dest = '0; bus.i_exmem_reg_write = 0;
        bus.i_memwb_dest = '0; bus.i_memwb_reg_write = 0;
    endtask

    task automatic randInstr();
        bus.i_hold = 0; bus.i_flush = 0; bus.i_valid = 1;
        bus.i_rs_data = $urandom; bus.i_rt_data = $urandom; bus.i_imm = $urandom;
        bus.i_rs = 5'($urandom); bus.i_rt = 5'($urandom); bus.i_dest = 5'($urandom);
        bus.i_uses_rt = 1'($urandom); bus.i_reg_write = 1'($urandom);
        bus.i_mem_read = 1'($urandom); bus.i_ctrl = CW'($urandom);
    endtask

    task automatic setInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                            input logic usesRt, input logic memRead);
        randInstr();
        bus.i_rs = rs; bus.i_rt = rt; bus.i_dest = dest;
        bus.i_uses_rt = usesRt; bus.i_mem_read = memRead; bus.i_reg_write = 1;
    endtask

    task automatic test_reset();
        reset = 1;
        randInstr();
        bus.i_exmem_reg_write = 1; bus.i_exmem_dest = bus.i_rs;
        tick(); tick();
        checks++;
        if (dutEx() !== instr_t'('0)) begin
            errors++; $display("[TB] FAIL reset_regs: got %h expected 0", dutEx());
        end
        checks++;
        if ({bus.o_fwd_sel_a, bus.o_fwd_sel_b, bus.o_stall} !== 5'b0) begin
            errors++; $display("[TB] FAIL reset_sel_stall: got %b expected 00000",
                               {bus.o_fwd_sel_a, bus.o_fwd_sel_b, bus.o_stall});
        end
        reset = 0;
        setIdle();
        tick();
        checks++;
        if (dutEx() !== instr_t'('0) || bus.o_stall_count !== '0) begin
            errors++; $display("[TB] FAIL idle_after_reset: got %h cnt %0d expected 0",
                               dutEx(), bus.o_stall_count);
        end
    endtask

    task automatic test_load_use();
        setInstr(5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        tick();
        setInstr(5'd5, 5'd7, 5'd9, 1'b1, 1'b0);
        #1;
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL load_use_rs_stall: got %b expected 1", bus.o_stall);
        end
        tick();
        checks++;
        if ({bus.o_valid, bus.o_stall, bus.o_stall_count} !== {1'b0, 1'b0, CNT_W'(1)}) begin
            errors++; $display("[TB] FAIL load_use_bubble: got v=%b st=%b cnt=%0d expected v=0 st=0 cnt=1",
                               bus.o_valid, bus.o_stall, bus.o_stall_count);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_rs !== 5'd5) begin
            errors++; $display("[TB] FAIL load_use_resume: got v=%b rs=%0d expected v=1 rs=5",
                               bus.o_valid, bus.o_rs);
        end
        setInstr(5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        tick();
        setInstr(5'd6, 5'd5, 5'd9, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus.o_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL load_use_rt_unused: got %b expected 0", bus.o_stall);
        end
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_rs !== 5'd6 || bus.o_stall_count !== CNT_W'(1)) begin
            errors++; $display("[TB] FAIL no_stall_load: got v=%b rs=%0d cnt=%0d expected v=1 rs=6 cnt=1",
                               bus.o_valid, bus.o_rs, bus.o_stall_count);
        end
    endtask

    task automatic test_forwarding();
        setIdle();
        setInstr(5'd3, 5'd4, 5'd8, 1'b1, 1'b0);
        tick();
        bus.i_exmem_dest = 5'd3; bus.i_exmem_reg_write = 1;
        bus.i_memwb_dest = 5'd3; bus.i_memwb_reg_write = 1;
        #1;
        checks++;
        if ({bus.o_fwd_sel_a, bus.o_fwd_sel_b} !== 4'b1000) begin
            errors++; $display("[TB] FAIL fwd_exmem_prio: got %b expected 1000",
                               {bus.o_fwd_sel_a, bus.o_fwd_sel_b});
        end
        bus.i_exmem_reg_write = 0;
        #1;
        checks++;
        if (bus.o_fwd_sel_a !== 2'b01) begin
            errors++; $display("[TB] FAIL fwd_memwb: got %b expected 01", bus.o_fwd_sel_a);
        end
        bus.i_exmem_dest = 5'd4; bus.i_exmem_reg_write = 1;
        #1;
        checks++;
        if ({bus.o_fwd_sel_a, bus.o_fwd_sel_b} !== 4'b0110) begin
            errors++; $display("[TB] FAIL fwd_both_ops: got %b expected 0110",
                               {bus.o_fwd_sel_a, bus.o_fwd_sel_b});
        end
        setInstr(5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        tick();
        bus.i_exmem_dest = 5'd0; bus.i_memwb_dest = 5'd0;
        bus.i_exmem_reg_write = 1; bus.i_memwb_reg_write = 1;
        #1;
        checks++;
        if ({bus.o_fwd_sel_a, bus.o_fwd_sel_b} !== 4'b0000) begin
            errors++; $display("[TB] FAIL fwd_reg_zero: got %b expected 0000",
                               {bus.o_fwd_sel_a, bus.o_fwd_sel_b});
        end
        setInstr(5'd3, 5'd4, 5'd8, 1'b1, 1'b0);
        bus.i_valid = 0;
        tick();
        bus.i_exmem_dest = 5'd3; bus.i_memwb_dest = 5'd4;
        #1;
        checks++;
        if ({bus.o_fwd_sel_a, bus.o_fwd_sel_b} !== 4'b0000) begin
            errors++; $display("[TB] FAIL fwd_invalid: got %b expected 0000",
                               {bus.o_fwd_sel_a, bus.o_fwd_sel_b});
        end
        setIdle();
    endtask

    task automatic test_flush();
        setInstr(5'd1, 5'd2, 5'd6, 1'b1, 1'b0);
        bus.i_flush = 1;
        tick();
        checks++;
        if ({bus.o_valid, bus.o_reg_write} !== 2'b00 || bus.o_rs_data !== '0) begin
            errors++; $display("[TB] FAIL flush_bubble: got v=%b rw=%b rsd=%h expected 0 0 0",
                               bus.o_valid, bus.o_reg_write, bus.o_rs_data);
        end
        setInstr(5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        tick();
        setInstr(5'd5, 5'd7, 5'd9, 1'b1, 1'b0);
        bus.i_flush = 1;
        tick();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_stall_count !== CNT_W'(2)) begin
            errors++; $display("[TB] FAIL flush_stall_bubble: got v=%b cnt=%0d expected v=0 cnt=2",
                               bus.o_valid, bus.o_stall_count);
        end
        bus.i_flush = 0;
        tick();
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_rs !== 5'd5) begin
            errors++; $display("[TB] FAIL flush_stall_single: got v=%b rs=%0d expected v=1 rs=5",
                               bus.o_valid, bus.o_rs);
        end
    endtask

    task automatic test_hold();
        instr_t a;
        instr_t b;
        setInstr(5'd10, 5'd11, 5'd12, 1'b1, 1'b0);
        a = idInstr();
        tick();
        randInstr();
        bus.i_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dutEx() !== a || bus.o_stall_count !== CNT_W'(2)) begin
                errors++; $display("[TB] FAIL hold_keep[%0d]: got %h cnt %0d expected %h cnt 2",
                                   i, dutEx(), bus.o_stall_count, a);
            end
        end
        setInstr(5'd20, 5'd21, 5'd22, 1'b1, 1'b0);
        b = idInstr();
        tick();
        checks++;
        if (dutEx() !== b) begin
            errors++; $display("[TB] FAIL hold_resume: got %h expected %h", dutEx(), b);
        end
        setInstr(5'd1, 5'd2, 5'd5, 1'b0, 1'b1);
        tick();
        setInstr(5'd5, 5'd7, 5'd9, 1'b1, 1'b0);
        bus.i_hold = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.o_stall !== 1'b1 || bus.o_stall_count !== CNT_W'(2)) begin
                errors++; $display("[TB] FAIL hold_stall[%0d]: got st=%b cnt=%0d expected st=1 cnt=2",
                                   i, bus.o_stall, bus.o_stall_count);
            end
        end
        bus.i_hold = 0;
        tick();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_stall_count !== CNT_W'(3)) begin
            errors++; $display("[TB] FAIL hold_release_stall: got v=%b cnt=%0d expected v=0 cnt=3",
                               bus.o_valid, bus.o_stall_count);
        end
    endtask

    task automatic test_saturation();
        int guard = 0;
        setInstr(5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
        for (int i = 0; i < 2 * (MAXC + 3); i++) begin
            tick();
            checks++;
            if (bus.o_stall_count !== CNT_W'(mCount)) begin
                errors++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d",
                                   i, bus.o_stall_count, mCount);
            end
        end
        checks++;
        if (bus.o_stall_count !== CNT_W'(MAXC)) begin
            errors++; $display("[TB] FAIL sat_final: got %0d expected %0d", bus.o_stall_count, MAXC);
        end
        while (!modelStall() && guard < 4) begin
            tick();
            guard++;
        end
        checks++;
        if (bus.o_stall !== 1'b1) begin
            errors++; $display("[TB] FAIL sat_stall_setup: got %b expected 1", bus.o_stall);
        end
        reset = 1;
        tick();
        checks++;
        if ({bus.o_stall, bus.o_valid} !== 2'b00 || bus.o_stall_count !== '0) begin
            errors++; $display("[TB] FAIL reset_in_stall: got st=%b v=%b cnt=%0d expected 0 0 0",
                               bus.o_stall, bus.o_valid, bus.o_stall_count);
        end
        reset = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            randInstr();
            bus.i_rs   = 5'($urandom_range(3, 0));
            bus.i_rt   = 5'($urandom_range(3, 0));
            bus.i_dest = 5'($urandom_range(3, 0));
            bus.i_valid = ($urandom_range(9, 0) != 0);
            bus.i_hold  = ($urandom_range(7, 0) == 0);
            bus.i_flush = ($urandom_range(9, 0) == 0);
            bus.i_exmem_dest = 5'($urandom_range(3, 0)); bus.i_exmem_reg_write = 1'($urandom);
            bus.i_memwb_dest = 5'($urandom_range(3, 0)); bus.i_memwb_reg_write = 1'($urandom);
            reset = ($urandom_range(49, 0) == 0);
            #1;
            checks++;
            if ({bus.o_stall, bus.o_fwd_sel_a, bus.o_fwd_sel_b} !==
                {modelStall(), modelFwd(mEx.rs), modelFwd(mEx.rt)}) begin
                errors++; $display("[TB] FAIL rand_comb[%0d]: got %b expected %b", i,
                                   {bus.o_stall, bus.o_fwd_sel_a, bus.o_fwd_sel_b},
                                   {modelStall(), modelFwd(mEx.rs), modelFwd(mEx.rt)});
            end
            tick();
            checks++;
            if (dutEx() !== mEx || bus.o_stall_count !== CNT_W'(mCount)) begin
                errors++; $display("[TB] FAIL rand_regs[%0d]: got %h cnt %0d expected %h cnt %0d",
                                   i, dutEx(), bus.o_stall_count, mEx, mCount);
            end
        end
        reset = 0;
    endtask

    initial begin
        setIdle();
        test_reset();
        test_load_use();
        test_forwarding();
        test_flush();
        test_hold();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
